// File: rtl/sample_voice.sv
// -----------------------------------------------------------------------------
// sample_voice : per-instrument playback voice
//
// On a trigger the voice streams 16-bit signed PCM words from sample memory
// into a small prefetch FIFO and offers them to the sample mixer on a
// valid/ready handshake, together with the velocity latched at trigger time.
//
// Optional feature macro: SAMPLE_VOICE_CHOKE_EN
//   defined   : choke in PLAY aborts playback (flush, discard in-flight reads,
//               go IDLE); a same-cycle trigger wins and restarts the voice.
//   undefined : the choke port is present but ignored.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   trigger           single-cycle start/restart pulse
//   trigger_velocity  velocity latched on an accepted trigger
//   sample_start      first word address, latched on trigger
//   sample_length     word count, latched on trigger (0 = trigger ignored)
//   choke             stop request (see macro above)
//   mem_addr/mem_req  read request, transfers when mem_req && mem_ready
//   mem_ready         memory accepts a request
//   mem_rdata/rvalid  in-order read data, latency >= 1 cycle
//   dout/dout_valid   FIFO head offered to the mixer
//   dout_ready        mixer accepts dout
//   velocity          latched velocity, held after playback ends
//   busy              voice is not IDLE
// -----------------------------------------------------------------------------
module sample_voice #(
    parameter int ADDR_WIDTH      = 20,
    parameter int FIFO_DEPTH      = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  trigger,
    input  logic [6:0]            trigger_velocity,
    input  logic [ADDR_WIDTH-1:0] sample_start,
    input  logic [ADDR_WIDTH-1:0] sample_length,
    input  logic                  choke,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_req,
    input  logic                  mem_ready,
    input  logic [15:0]           mem_rdata,
    input  logic                  mem_rvalid,
    output logic [15:0]           dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic [6:0]            velocity,
    output logic                  busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    // Wide enough to hold fifo_count + outstanding without wrapping.
    localparam int CNT_W = $clog2(FIFO_DEPTH + MAX_OUTSTANDING + 1);

    typedef enum logic {IDLE, PLAY} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH-1:0]   words_left_q, words_left_d;
    logic [CNT_W-1:0]        fifo_cnt_q, fifo_cnt_d;
    logic [CNT_W-1:0]        outstanding_q, outstanding_d;
    logic [CNT_W-1:0]        discard_q, discard_d;
    logic [PTR_W-1:0]        wr_idx_q, wr_idx_d;
    logic [PTR_W-1:0]        rd_idx_q, rd_idx_d;
    logic [6:0]              velocity_q, velocity_d;
    logic [15:0]             fifo_mem [FIFO_DEPTH];

    logic play, trig_go, choke_go, flush, req_acc, drop, push, pop;

    assign play    = (state_q == PLAY);
    assign trig_go = trigger && (sample_length != '0);

`ifdef SAMPLE_VOICE_CHOKE_EN
    assign choke_go = choke && play && !trig_go;
`else
    logic unused_choke;
    assign unused_choke = choke;
    assign choke_go     = 1'b0;
`endif

    assign flush = trig_go || choke_go;

    // Credit rule: never have more words in flight or buffered than the FIFO holds.
    assign mem_req  = play && (words_left_q != '0)
                      && ((fifo_cnt_q + outstanding_q) < CNT_W'(FIFO_DEPTH))
                      && (outstanding_q < CNT_W'(MAX_OUTSTANDING));
    assign mem_addr = rd_ptr_q;
    assign req_acc  = mem_req && mem_ready;

    // Responses belonging to an abandoned sample are dropped first.
    assign drop = mem_rvalid && (discard_q != '0);
    assign push = mem_rvalid && !drop && !flush;

    assign dout_valid = play && (fifo_cnt_q != '0) && !trigger;
    assign pop        = dout_valid && dout_ready;
    assign dout       = (fifo_cnt_q != '0) ? fifo_mem[rd_idx_q] : '0;
    assign velocity   = velocity_q;
    assign busy       = play;

    always_comb begin
        state_d       = state_q;
        rd_ptr_d      = rd_ptr_q + ADDR_WIDTH'(req_acc);
        words_left_d  = words_left_q - ADDR_WIDTH'(req_acc);
        velocity_d    = velocity_q;
        outstanding_d = outstanding_q + CNT_W'(req_acc) - CNT_W'(mem_rvalid);

        if (flush) begin
            // Every read still in flight after this edge belongs to the old
            // sample, including one accepted in this very cycle.
            fifo_cnt_d = '0;
            wr_idx_d   = '0;
            rd_idx_d   = '0;
            discard_d  = outstanding_d;
        end else begin
            fifo_cnt_d = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
            wr_idx_d   = wr_idx_q + PTR_W'(push);
            rd_idx_d   = rd_idx_q + PTR_W'(pop);
            discard_d  = discard_q - CNT_W'(drop);
        end

        if (trig_go) begin
            state_d      = PLAY;
            rd_ptr_d     = sample_start;
            words_left_d = sample_length;
            velocity_d   = trigger_velocity;
        end else if (choke_go) begin
            state_d      = IDLE;
            words_left_d = '0;
        end else if (play && (words_left_d == '0) && (outstanding_d == '0)
                     && (fifo_cnt_d == '0)) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            rd_ptr_q      <= '0;
            words_left_q  <= '0;
            fifo_cnt_q    <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
            wr_idx_q      <= '0;
            rd_idx_q      <= '0;
            velocity_q    <= '0;
        end else begin
            state_q       <= state_d;
            rd_ptr_q      <= rd_ptr_d;
            words_left_q  <= words_left_d;
            fifo_cnt_q    <= fifo_cnt_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            wr_idx_q      <= wr_idx_d;
            rd_idx_q      <= rd_idx_d;
            velocity_q    <= velocity_d;
        end
    end

    // FIFO storage is pure data and needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_idx_q] <= mem_rdata;
        end
    end

`ifndef SYNTHESIS
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && (fifo_cnt_q == CNT_W'(FIFO_DEPTH))));
`endif

endmodule

// File: tb/tb_sample_voice.sv
module tb_sample_voice;

    localparam int AW = 20;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          trigger;
    logic [6:0]    trigger_velocity;
    logic [AW-1:0] sample_start;
    logic [AW-1:0] sample_length;
    logic          choke;
    logic [AW-1:0] mem_addr;
    logic          mem_req;
    logic          mem_ready;
    logic [15:0]   mem_rdata;
    logic          mem_rvalid;
    logic [15:0]   dout;
    logic          dout_valid;
    logic          dout_ready;
    logic [6:0]    velocity;
    logic          busy;

    sample_voice #(.ADDR_WIDTH(AW), .FIFO_DEPTH(4), .MAX_OUTSTANDING(4)) dut (
        .clk(clk), .rst_n(rst_n), .trigger(trigger),
        .trigger_velocity(trigger_velocity), .sample_start(sample_start),
        .sample_length(sample_length), .choke(choke),
        .mem_addr(mem_addr), .mem_req(mem_req), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .velocity(velocity), .busy(busy)
    );

    always #5 clk = ~clk;

    // Bench state
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int n_acc = 0;
    int n_pop = 0;
    int last_pop_cyc = -1;
    int lat = 2;
    int last_due = 0;
    int rdy_mode = 0;   // 0 hold low, 1 always high, 2 random, 3 one pulse per 50 cycles
    bit rand_ready = 1'b0;
    bit rand_lat = 1'b0;
    logic [6:0] exp_vel = 7'd0;

    typedef struct {
        logic [15:0] d;
        int          due;
    } rsp_t;

    logic [15:0]   sb_q[$];    // expected dout sequence
    logic [AW-1:0] addr_q[$];  // expected request addresses
    rsp_t          rq[$];      // memory responses in flight

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] mem_word(input logic [AW-1:0] a);
        logic [31:0] t;
        t = {12'd0, a} * 32'd40503 + 32'h1357;
        return t[23:8];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name, input string msg);
        checks++;
        errors++;
        $display("FAIL %s: %s (cycle %0d)", name, msg, cyc);
    endtask

    // Memory model: in-order responses with fixed or random latency.
    initial begin
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            rsp_t r;
            int   due;
            @(negedge clk);
            mem_rvalid = 1'b0;
            if (rq.size() > 0 && rq[0].due <= cyc) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rq[0].d;
                void'(rq.pop_front());
            end
            mem_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (rst_n && mem_req && mem_ready) begin
                n_acc++;
                if (addr_q.size() == 0) fail("mem_addr", "request with no address expected");
                else chk("mem_addr", 32'(mem_addr), 32'(addr_q.pop_front()));
                due = cyc + (rand_lat ? int'($urandom_range(1, 5)) : lat);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                r.d   = mem_word(mem_addr);
                r.due = due;
                rq.push_back(r);
            end
        end
    end

    // Mixer ready generator
    initial begin
        dout_ready = 1'b0;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       dout_ready = 1'b0;
                1:       dout_ready = 1'b1;
                2:       dout_ready = 1'($urandom_range(0, 1));
                default: dout_ready = (cyc % 50 == 0);
            endcase
        end
    end

    // Monitor: checks every handshaken word against the scoreboard.
    always @(negedge clk) begin
        #2;
        if (rst_n && dout_valid && dout_ready) begin
            if (sb_q.size() == 0) fail("dout", "word delivered with none expected");
            else chk("dout", 32'(dout), 32'(sb_q.pop_front()));
            chk("velocity", 32'(velocity), 32'(exp_vel));
            last_pop_cyc = cyc;
            n_pop++;
        end
    end

    task automatic do_trigger(input logic [AW-1:0] st, input logic [AW-1:0] len,
                              input logic [6:0] vel);
        @(negedge clk);
        trigger          = 1'b1;
        sample_start     = st;
        sample_length    = len;
        trigger_velocity = vel;
        #3;
        chk("dout_valid_at_trigger", 32'(dout_valid), 0);
        if (len != 0) begin
            sb_q.delete();
            addr_q.delete();
            exp_vel = vel;
            for (int i = 0; i < int'(len); i++) begin
                addr_q.push_back(st + AW'(i));
                sb_q.push_back(mem_word(st + AW'(i)));
            end
        end
        @(negedge clk);
        trigger = 1'b0;
    endtask

    task automatic wait_idle(input int limit, output int when);
        int n;
        n    = 0;
        when = -1;
        while (n < limit) begin
            #1;
            if (!busy) begin
                when = cyc;
                break;
            end
            @(negedge clk);
            n++;
        end
        if (when < 0) fail("idle_timeout", "voice never returned to IDLE");
    endtask

    task automatic wait_acc(input int target, input int limit);
        int n;
        n = 0;
        while (n_acc < target && n < limit) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (n_acc < target) fail("acc_timeout", "expected requests were not issued");
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int when;
        int base;
        rst_n = 1'b0; trigger = 1'b0; trigger_velocity = '0;
        sample_start = '0; sample_length = '0; choke = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_dout", 32'(dout), 0);
        chk("rst_dout_valid", 32'(dout_valid), 0);
        chk("rst_velocity", 32'(velocity), 0);
        chk("rst_busy", 32'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic playback, slow mixer
        lat = 2; rdy_mode = 3; base = n_acc;
        do_trigger(20'h00100, 20'd3, 7'd100);
        wait_idle(400, when);
        chk("busy_fall_cycle", 32'(when), 32'(last_pop_cyc + 1));
        chk("t1_requests", 32'(n_acc - base), 3);
        chk("t1_velocity_hold", 32'(velocity), 100);
        chk("t1_sb_empty", 32'(sb_q.size()), 0);

        // Credit limit with a stalled mixer
        lat = 1; rdy_mode = 0; base = n_acc;
        do_trigger(20'h00300, 20'd8, 7'd5);
        repeat (20) @(negedge clk);
        #1;
        chk("t2_requests_stalled", 32'(n_acc - base), 4);
        chk("t2_mem_req_stalled", 32'(mem_req), 0);
        chk("t2_dout_valid", 32'(dout_valid), 1);
        rdy_mode = 1;
        wait_idle(200, when);
        chk("t2_requests_total", 32'(n_acc - base), 8);
        chk("t2_sb_empty", 32'(sb_q.size()), 0);

        // Retrigger with reads in flight
        lat = 6; rdy_mode = 1; base = n_acc;
        do_trigger(20'h00400, 20'd10, 7'd7);
        wait_acc(base + 3, 50);
        do_trigger(20'h00200, 20'd5, 7'd9);
        wait_idle(300, when);
        chk("t3_sb_empty", 32'(sb_q.size()), 0);
        chk("t3_velocity", 32'(velocity), 9);

        // Zero-length trigger is ignored
        base = n_acc;
        do_trigger(20'h00500, 20'd0, 7'd33);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t4_busy", 32'(busy), 0);
            chk("t4_mem_req", 32'(mem_req), 0);
            @(negedge clk);
        end
        chk("t4_velocity", 32'(velocity), 9);
        chk("t4_requests", 32'(n_acc - base), 0);

        // Address wrap with a jittery memory
        rand_ready = 1'b1; rand_lat = 1'b1; rdy_mode = 2;
        do_trigger(20'hFFFFE, 20'd4, 7'd50);
        wait_idle(500, when);
        chk("t5_sb_empty", 32'(sb_q.size()), 0);

        // Choke mid-stream with two reads outstanding
        rand_ready = 1'b0; rand_lat = 1'b0; lat = 4; rdy_mode = 0; base = n_acc;
        do_trigger(20'h00600, 20'd6, 7'd60);
        wait_acc(base + 2, 50);
        @(negedge clk);
        choke = 1'b1;
        #3;
`ifdef SAMPLE_VOICE_CHOKE_EN
        sb_q.delete();
        addr_q.delete();
`endif
        @(negedge clk);
        choke = 1'b0;
        #1;
`ifdef SAMPLE_VOICE_CHOKE_EN
        chk("t6_busy_after_choke", 32'(busy), 0);
        chk("t6_dout_valid_after_choke", 32'(dout_valid), 0);
        rdy_mode = 1;
        do_trigger(20'h00700, 20'd3, 7'd61);
        wait_idle(300, when);
        chk("t6_sb_empty", 32'(sb_q.size()), 0);
`else
        chk("t6_busy_ignores_choke", 32'(busy), 1);
        rdy_mode = 1;
        wait_idle(300, when);
        chk("t6_sb_empty", 32'(sb_q.size()), 0);
`endif

        // Random playback with occasional retriggers
        rand_ready = 1'b1; rand_lat = 1'b1; rdy_mode = 2;
        for (int r = 0; r < 8; r++) begin
            do_trigger(AW'($urandom), AW'($urandom_range(1, 12)), 7'($urandom));
            repeat ($urandom_range(0, 15)) @(negedge clk);
            if ($urandom_range(0, 1) == 1)
                do_trigger(AW'($urandom), AW'($urandom_range(1, 12)), 7'($urandom));
            wait_idle(2000, when);
            chk("rand_sb_empty", 32'(sb_q.size()), 0);
        end
        chk("rand_velocity", 32'(velocity), 32'(exp_vel));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
